// File: rtl/baud_gen_pkg.sv
// Shared constants for the fractional baud generator: oversample default,
// minimum divisor and 50 MHz / 16x divisor presets for the standard rates.
package baud_gen_pkg;

    localparam int DEF_OS_RATE = 16;
    localparam int MIN_DIV     = 2;

    localparam int DIV_9600_INT    = 325;
    localparam int DIV_9600_FRAC   = 8;
    localparam int DIV_19200_INT   = 162;
    localparam int DIV_19200_FRAC  = 12;
    localparam int DIV_38400_INT   = 81;
    localparam int DIV_38400_FRAC  = 6;
    localparam int DIV_57600_INT   = 54;
    localparam int DIV_57600_FRAC  = 4;
    localparam int DIV_115200_INT  = 27;
    localparam int DIV_115200_FRAC = 2;

    typedef enum logic [2:0] {
        BAUD_9600,
        BAUD_19200,
        BAUD_38400,
        BAUD_57600,
        BAUD_115200
    } baud_sel_t;

    typedef struct packed {
        logic [15:0] div_int;
        logic [3:0]  div_frac;
    } baud_div_t;

    function automatic baud_div_t baud_preset(input baud_sel_t sel);
        baud_div_t d;
        case (sel)
            BAUD_19200:  d = '{div_int: 16'(DIV_19200_INT),  div_frac: 4'(DIV_19200_FRAC)};
            BAUD_38400:  d = '{div_int: 16'(DIV_38400_INT),  div_frac: 4'(DIV_38400_FRAC)};
            BAUD_57600:  d = '{div_int: 16'(DIV_57600_INT),  div_frac: 4'(DIV_57600_FRAC)};
            BAUD_115200: d = '{div_int: 16'(DIV_115200_INT), div_frac: 4'(DIV_115200_FRAC)};
            default:     d = '{div_int: 16'(DIV_9600_INT),   div_frac: 4'(DIV_9600_FRAC)};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/baud_frac_div.sv
// Period counter with fractional phase accumulator; emits a registered
// one-cycle os_tick every div_int or div_int+1 cycles.
module baud_frac_div
    import baud_gen_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              restart,
    input  logic [CNT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              wrap,
    output logic              os_tick
);

    logic [CNT_W-1:0]  cnt;
    logic [FRAC_W-1:0] frac_acc;
    logic              carry;
    logic [CNT_W:0]    len;
    logic [FRAC_W:0]   acc_sum;

    // The carry from the previous period's accumulation stretches this one.
    assign len     = {1'b0, div_int} + {{CNT_W{1'b0}}, carry};
    assign acc_sum = {1'b0, frac_acc} + {1'b0, div_frac};
    assign wrap    = enable && !restart && ({1'b0, cnt} == len - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            frac_acc <= '0;
            carry    <= 1'b0;
            os_tick  <= 1'b0;
        end else if (!enable || restart) begin
            cnt      <= '0;
            frac_acc <= '0;
            carry    <= 1'b0;
            os_tick  <= 1'b0;
        end else if (wrap) begin
            cnt               <= '0;
            {carry, frac_acc} <= acc_sum;
            os_tick           <= 1'b1;
        end else begin
            cnt     <= cnt + 1'b1;
            os_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: shadowed divisor with load/ack handshake, bit
// phase, bit strobe and stability flag. BAUDGEN_RESYNC_EN adds a resync input.
module baud_gen_frac
    import baud_gen_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int FRAC_W   = 4,
    parameter int OS_RATE  = DEF_OS_RATE,
    parameter int DEF_INT  = DIV_9600_INT,
    parameter int DEF_FRAC = DIV_9600_FRAC
) (
    input  logic                       system_clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [CNT_W-1:0]           div_int,
    input  logic [FRAC_W-1:0]          div_frac,
    input  logic                       div_load,
`ifdef BAUDGEN_RESYNC_EN
    input  logic                       resync,
`endif
    output logic                       div_ack,
    output logic                       os_tick,
    output logic                       bit_tick,
    output logic [$clog2(OS_RATE)-1:0] bit_phase,
    output logic                       clock_stable
);

    localparam int PH_W = $clog2(OS_RATE);

    logic [CNT_W-1:0]  int_active;
    logic [FRAC_W-1:0] frac_active;
    logic [CNT_W-1:0]  shadow_int;
    logic [FRAC_W-1:0] shadow_frac;
    logic              pending;
    logic              direct_apply;
    logic              shadow_apply;
    logic              apply;
    logic              resync_hit;
    logic              restart;
    logic              wrap;
    logic              last_phase;

    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : d;
    endfunction

`ifdef BAUDGEN_RESYNC_EN
    assign resync_hit = resync && enable;
`else
    assign resync_hit = 1'b0;
`endif

    // While idle there is no period boundary to wait for, so a fresh load
    // bypasses the shadow and a stale pending value applies immediately.
    assign direct_apply = div_load && !enable && !pending;
    assign shadow_apply = pending && (!enable || os_tick);
    assign apply        = direct_apply || shadow_apply;
    assign restart      = apply || resync_hit;
    assign last_phase   = (bit_phase == PH_W'(OS_RATE - 1));

    baud_frac_div #(
        .CNT_W  (CNT_W),
        .FRAC_W (FRAC_W)
    ) u_div (
        .clk      (system_clk),
        .rst_n    (reset_n),
        .enable   (enable),
        .restart  (restart),
        .div_int  (int_active),
        .div_frac (frac_active),
        .wrap     (wrap),
        .os_tick  (os_tick)
    );

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            int_active  <= CNT_W'(DEF_INT);
            frac_active <= FRAC_W'(DEF_FRAC);
            shadow_int  <= '0;
            shadow_frac <= '0;
            pending     <= 1'b0;
            div_ack     <= 1'b0;
        end else begin
            div_ack <= apply;
            if (direct_apply) begin
                int_active  <= clamp_div(div_int);
                frac_active <= div_frac;
            end else if (shadow_apply) begin
                int_active  <= shadow_int;
                frac_active <= shadow_frac;
            end
            // A load coinciding with an apply is kept for the next boundary.
            if (div_load && !direct_apply) begin
                shadow_int  <= clamp_div(div_int);
                shadow_frac <= div_frac;
                pending     <= 1'b1;
            end else if (shadow_apply) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_phase    <= '0;
            bit_tick     <= 1'b0;
            clock_stable <= 1'b0;
        end else begin
            bit_tick <= wrap && last_phase;
            if (!enable || apply)
                bit_phase <= '0;
            else if (resync_hit)
                bit_phase <= PH_W'(OS_RATE / 2);
            else if (os_tick)
                bit_phase <= bit_phase + 1'b1;
            if (!enable || apply)
                clock_stable <= 1'b0;
            else if (wrap && last_phase)
                clock_stable <= 1'b1;
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: divisor table, randomized divisors
// against a closed-form period model, and handshake/reset sequences.
module tb_baud_gen_frac;

    localparam int CNT_W   = 16;
    localparam int FRAC_W  = 4;
    localparam int OS_RATE = 16;

    logic              system_clk = 1'b0;
    logic              reset_n    = 1'b0;
    logic              enable     = 1'b0;
    logic              div_load   = 1'b0;
    logic [CNT_W-1:0]  div_int    = '0;
    logic [FRAC_W-1:0] div_frac   = '0;
`ifdef BAUDGEN_RESYNC_EN
    logic              resync     = 1'b0;
`endif
    logic              div_ack;
    logic              os_tick;
    logic              bit_tick;
    logic [3:0]        bit_phase;
    logic              clock_stable;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int di;
        int df;
        int first;
        int pmin;
        int pmax;
        int sum16;
    } vec_t;

    vec_t vecs[8];

    baud_gen_frac #(
        .CNT_W    (CNT_W),
        .FRAC_W   (FRAC_W),
        .OS_RATE  (OS_RATE),
        .DEF_INT  (325),
        .DEF_FRAC (8)
    ) dut (
        .system_clk   (system_clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .div_int      (div_int),
        .div_frac     (div_frac),
        .div_load     (div_load),
`ifdef BAUDGEN_RESYNC_EN
        .resync       (resync),
`endif
        .div_ack      (div_ack),
        .os_tick      (os_tick),
        .bit_tick     (bit_tick),
        .bit_phase    (bit_phase),
        .clock_stable (clock_stable)
    );

    always #5 system_clk = ~system_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Period k after a restart: d cycles plus the carries accumulated by
    // k additions of f, i.e. the growth of floor(k*f/2^FRAC_W).
    function automatic int model_period(input int d, input int f, input int k);
        if (k == 0) return d;
        return d + ((k * f) >> FRAC_W) - (((k - 1) * f) >> FRAC_W);
    endfunction

    task automatic wait_tick(input string tag, input int limit, output int gap,
                             output bit ok, output int acks);
        gap  = 0;
        acks = 0;
        do begin
            @(negedge system_clk);
            gap++;
            if (div_ack) acks++;
        end while (!os_tick && gap < limit);
        ok = os_tick;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: no os_tick within %0d cycles, expected one", tag, limit);
        end
    endtask

    task automatic go_idle(input string tag);
        enable = 1'b0;
        repeat (2) @(negedge system_clk);
        check({tag, ".idle_os_tick"}, os_tick, 0);
        check({tag, ".idle_bit_phase"}, bit_phase, 0);
        check({tag, ".idle_stable"}, clock_stable, 0);
    endtask

    task automatic load_idle(input string tag, input int d, input int f);
        div_int  = CNT_W'(d);
        div_frac = FRAC_W'(f);
        div_load = 1'b1;
        @(negedge system_clk);
        div_load = 1'b0;
        check({tag, ".ack"}, div_ack, 1);
        @(negedge system_clk);
        check({tag, ".ack_pulse"}, div_ack, 0);
    endtask

    // Enables the generator and follows 17 os_ticks with per-tick checks.
    task automatic run_and_check(input string tag, input int d, input int f,
                                 output int sum16, output int pmin, output int pmax);
        int gap, acks, total_acks;
        bit ok;
        sum16 = 0;
        pmin = 1 << 30;
        pmax = 0;
        total_acks = 0;
        enable = 1'b1;
        wait_tick(tag, 2 * d + 8, gap, ok, acks);
        if (!ok) return;
        check({tag, ".first_gap"}, gap, d);
        for (int k = 1; k <= 17; k++) begin
            if (k > 1) begin
                wait_tick(tag, 2 * d + 8, gap, ok, acks);
                if (!ok) return;
                total_acks += acks;
                check($sformatf("%s.period%0d", tag, k - 1), gap, model_period(d, f, k - 1));
                sum16 += gap;
                if (gap < pmin) pmin = gap;
                if (gap > pmax) pmax = gap;
            end
            check($sformatf("%s.bit_phase%0d", tag, k), bit_phase, (k - 1) % OS_RATE);
            check($sformatf("%s.bit_tick%0d", tag, k), bit_tick, (k % OS_RATE) == 0);
            check($sformatf("%s.stable%0d", tag, k), clock_stable, k >= OS_RATE);
        end
        check({tag, ".no_stray_ack"}, total_acks, 0);
    endtask

    task automatic seq_retime();
        int s, mn, mx, gap, acks, n, ticks, bticks;
        bit ok;
        go_idle("retime");
        load_idle("retime", 4, 0);
        run_and_check("retime.pre", 4, 0, s, mn, mx);
        check("retime.stable_before", clock_stable, 1);
        @(negedge system_clk);
        div_int  = 16'd10;
        div_frac = 4'd0;
        div_load = 1'b1;
        @(negedge system_clk);
        div_load = 1'b0;
        check("retime.no_early_ack", div_ack, 0);
        wait_tick("retime.boundary", 8, gap, ok, acks);
        check("retime.acks_before_boundary", acks, 0);
        @(negedge system_clk);
        check("retime.ack", div_ack, 1);
        check("retime.phase_restart", bit_phase, 0);
        check("retime.stable_dropped", clock_stable, 0);
        n = 0;
        ticks = 0;
        bticks = 0;
        acks = 0;
        do begin
            @(negedge system_clk);
            n++;
            if (os_tick) ticks++;
            if (bit_tick) bticks++;
            if (div_ack) acks++;
        end while (!clock_stable && n < 400);
        check("retime.stable_delay", n, 160);
        check("retime.os_ticks", ticks, 16);
        check("retime.bit_ticks", bticks, 1);
        check("retime.bit_tick_at_stable", bit_tick, 1);
        check("retime.single_ack", acks, 0);
    endtask

    task automatic seq_double_load();
        int gap, acks;
        bit ok;
        wait_tick("dbl.sync", 24, gap, ok, acks);
        @(negedge system_clk);
        div_int  = 16'd6;
        div_frac = 4'd0;
        div_load = 1'b1;
        @(negedge system_clk);
        div_int  = 16'd8;
        @(negedge system_clk);
        div_load = 1'b0;
        wait_tick("dbl.boundary", 24, gap, ok, acks);
        check("dbl.acks_before_boundary", acks, 0);
        @(negedge system_clk);
        check("dbl.ack", div_ack, 1);
        wait_tick("dbl.p1", 24, gap, ok, acks);
        check("dbl.period_a", gap, 8);
        check("dbl.no_second_ack_a", acks, 0);
        wait_tick("dbl.p2", 24, gap, ok, acks);
        check("dbl.period_b", gap, 8);
        check("dbl.no_second_ack_b", acks, 0);
        // Divisor 1 must be clamped to a 2-cycle period.
        @(negedge system_clk);
        div_int  = 16'd1;
        div_load = 1'b1;
        @(negedge system_clk);
        div_load = 1'b0;
        wait_tick("clamp.boundary", 24, gap, ok, acks);
        @(negedge system_clk);
        check("clamp.ack", div_ack, 1);
        wait_tick("clamp.p1", 8, gap, ok, acks);
        check("clamp.period_a", gap, 2);
        wait_tick("clamp.p2", 8, gap, ok, acks);
        check("clamp.period_b", gap, 2);
        check("clamp.single_ack", acks, 0);
        @(negedge system_clk);
        check("clamp.no_adjacent_tick", os_tick, 0);
    endtask

    task automatic seq_reset();
        int s, mn, mx;
        go_idle("rst");
        load_idle("rst", 7, 0);
        run_and_check("rst.pre", 7, 0, s, mn, mx);
        repeat (3) @(negedge system_clk);
        check("rst.pre_phase", bit_phase, 1);
        check("rst.pre_stable", clock_stable, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rst.async_os_tick", os_tick, 0);
        check("rst.async_bit_tick", bit_tick, 0);
        check("rst.async_bit_phase", bit_phase, 0);
        check("rst.async_ack", div_ack, 0);
        check("rst.async_stable", clock_stable, 0);
        enable = 1'b0;
        @(negedge system_clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge system_clk);
            check($sformatf("rst.idle_os_tick%0d", i), os_tick, 0);
        end
        run_and_check("rst.post", 325, 8, s, mn, mx);
        check("rst.post_sum16", s, 5208);
    endtask

    initial begin
        int s, mn, mx, d, f, deff;

        vecs[0] = '{325,  8, 325, 325, 326, 5208};
        vecs[1] = '{  4,  0,   4,   4,   4,   64};
        vecs[2] = '{  4,  8,   4,   4,   5,   72};
        vecs[3] = '{  1,  0,   2,   2,   2,   32};
        vecs[4] = '{  1, 15,   2,   2,   3,   47};
        vecs[5] = '{ 10,  3,  10,  10,  11,  163};
        vecs[6] = '{  0,  1,   2,   2,   3,   33};
        vecs[7] = '{ 19, 12,  19,  19,  20,  316};

        repeat (3) @(negedge system_clk);
        check("reset.os_tick", os_tick, 0);
        check("reset.bit_tick", bit_tick, 0);
        check("reset.bit_phase", bit_phase, 0);
        check("reset.div_ack", div_ack, 0);
        check("reset.stable", clock_stable, 0);
        reset_n = 1'b1;
        @(negedge system_clk);

        run_and_check("defaults", 325, 8, s, mn, mx);
        check("defaults.sum16", s, 5208);

        for (int i = 0; i < 8; i++) begin
            go_idle($sformatf("vec%0d", i));
            load_idle($sformatf("vec%0d", i), vecs[i].di, vecs[i].df);
            run_and_check($sformatf("vec%0d", i), vecs[i].first, vecs[i].df, s, mn, mx);
            check($sformatf("vec%0d.sum16", i), s, vecs[i].sum16);
            check($sformatf("vec%0d.min", i), mn, vecs[i].pmin);
            check($sformatf("vec%0d.max", i), mx, vecs[i].pmax);
        end

        for (int i = 0; i < 6; i++) begin
            d = int'($urandom_range(0, 12));
            f = int'($urandom_range(0, 15));
            deff = (d < 2) ? 2 : d;
            go_idle($sformatf("rnd%0d", i));
            load_idle($sformatf("rnd%0d", i), d, f);
            run_and_check($sformatf("rnd%0d_d%0d_f%0d", i, d, f), deff, f, s, mn, mx);
            check($sformatf("rnd%0d.sum16", i), s, 16 * deff + f);
        end

        seq_retime();
        seq_double_load();
        seq_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
Parametrised fractional baud generator: the next-generation rate source for the UART TX/RX paths. Produces a single-cycle oversample strobe (os_tick) at a runtime-programmable integer+fractional divisor, and a per-bit strobe (bit_tick) every OS_RATE oversample ticks. Divisor updates are glitch-free: they go through a shadow register with a load/ack handshake. A stability flag reports when a full bit period has completed on an unchanged divisor.

Parameters:
CNT_W, 16, width of integer divisor and period counter
FRAC_W, 4, width of fractional divisor and phase accumulator
OS_RATE, 16, oversample ticks per bit; power of two, >=4
DEF_INT, 325, integer divisor after reset (50 MHz, 9600 bd, 16x)
DEF_FRAC, 8, fractional divisor after reset

Ports:
system_clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run generator; low holds counters cleared
div_int  in  CNT_W  requested integer divisor
div_frac  in  FRAC_W  requested fractional divisor (units of 1/2^FRAC_W)
div_load  in  1  one-cycle request to capture div_int/div_frac
div_ack  out  1  one-cycle pulse when captured divisor becomes active
os_tick  out  1  oversample strobe, one cycle wide
bit_tick  out  1  bit strobe, coincident with the os_tick that wraps bit_phase
bit_phase  out  $clog2(OS_RATE)  oversample index within current bit
clock_stable  out  1  high once a full bit period has elapsed on the active divisor

Behaviour:
- Reset (async, reset_n low): active divisor = DEF_INT/DEF_FRAC; shadow empty; period counter, frac_acc, bit_phase = 0; os_tick, bit_tick, div_ack, clock_stable = 0.
- Period: counter runs 0..len-1; os_tick=1 in the cycle counter==len-1, then the counter wraps to 0. len = div_int_active + carry.
- Fractional: on each os_tick, {carry, frac_acc} <= frac_acc + frac_active (FRAC_W+1-bit add); that carry sets len of the next period. First period after enable or divisor apply uses carry=0. Any 2^FRAC_W consecutive periods total exactly 2^FRAC_W*div_int + div_frac cycles.
- Clamp: captured div_int < 2 is stored as 2. os_tick is never high in consecutive cycles.
- bit_phase increments on each os_tick and wraps OS_RATE-1 -> 0. bit_tick=1 on the os_tick where bit_phase==OS_RATE-1.
- Handshake: div_load=1 captures inputs into the shadow and sets pending. A second div_load while pending overwrites the shadow (last wins; only one ack is issued).
  - enable=1: pending shadow applies in the cycle after the next os_tick. Counter, frac_acc and bit_phase restart at 0; div_ack=1 that cycle.
  - enable=0: applies the cycle after capture, with div_ack=1.
  - div_load in the same cycle as an apply: the new value is captured and stays pending for the next boundary.
- enable=0: counter, frac_acc, bit_phase held at 0; os_tick, bit_tick, clock_stable = 0. On enable 0->1, first os_tick comes div_int_active cycles later.
- clock_stable: set on the first bit_tick after enable rise or divisor apply; cleared on apply, enable low, or reset. All other outputs registered; ticks are 1-cycle pulses.

Optional Feature:
BAUDGEN_RESYNC_EN: adds input resync (1 bit). A resync pulse clears counter and frac_acc and sets bit_phase to OS_RATE/2 (RX start-edge alignment), so the next bit_tick lands OS_RATE/2 ticks later. If resync and a divisor apply coincide, the apply wins and bit_phase=0. Without the macro, the port is absent and alignment is fixed by enable and divisor apply only.

Decomposition:
- Package baud_gen_pkg: default OS_RATE, minimum-divisor constant (2), and divisor int/frac constants for 9600/19200/38400/57600/115200 at 50 MHz and 16x.
- Sub-module baud_frac_div: period counter + fractional accumulator producing os_tick, with a restart input.
- Top level holds the shadow/handshake, bit_phase, bit_tick and clock_stable.

Test Plan:
- Reset release, enable=1, defaults -> first os_tick 325 cycles after enable; 16 consecutive os periods total 5208 cycles; bit_tick every 16 os_ticks.
- div_int=4, div_frac=0, load while disabled -> div_ack next cycle; after enable, os_tick every 4 cycles, bit_tick every 64, clock_stable rises at first bit_tick.
- div_int=4, div_frac=8 -> periods of 4/5 cycles, any 16 consecutive periods = 72 cycles; never two adjacent os_ticks.
- Running at div 4, load div 10 mid-period -> div_ack the cycle after the next os_tick; bit_phase restarts at 0; clock_stable drops and re-rises after 160 cycles.
- Two div_load pulses (div 6 then 8) before a boundary, plus div_int=1 -> single div_ack, div 8 applied; div_int=1 applies as period 2.
- reset_n low mid-period, then enable toggled low/high -> all outputs 0 immediately; defaults restored; first os_tick DEF_INT cycles after enable rise.
